dep_issue_scheduler: RTL and testbench



---
 rtl/dep_issue_scheduler_pkg.sv | 16 +
 rtl/dep_issue_scheduler_prio_enc.sv | 21 ++
 rtl/dep_issue_scheduler.sv | 97 +++++++++
 tb/tb_dep_issue_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dep_issue_scheduler_pkg.sv
// Shared types and sizing for the dependency issue scheduler.
// Index and count widths are also consumed by the IRT.
package dep_issue_scheduler_pkg;

  localparam int BS    = 32;
  localparam int IDX_W = $clog2(BS);
  localparam int CNT_W = $clog2(BS + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } entry_state_t;

endpackage

// File: rtl/dep_issue_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder.
// index is zero when no request bit is set.
module prio_enc_lsb #(
  parameter int n = 32
) (
  input  logic [n-1:0]         req,
  output logic                 found,
  output logic [$clog2(n)-1:0] index
);

  localparam int w = $clog2(n);

  always_comb begin
    found = |req;
    index = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (req[i]) index = w'(i);
    end
  end

endmodule

// File: rtl/dep_issue_scheduler.sv
// Consumer side of the instruction relation table: tracks per-entry
// dependency rows, wakes entries as producers complete, issues lowest ready.
module dep_issue_scheduler
  import dep_issue_scheduler_pkg::*;
#(
  parameter int bs = BS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [$clog2(bs)-1:0]  alloc_index,
  input  logic [0:bs-1]          alloc_dept,
  output logic                   issue_valid,
  output logic [$clog2(bs)-1:0]  issue_index,
  input  logic                   issue_ready,
  input  logic                   cmpl_valid,
  input  logic [$clog2(bs)-1:0]  cmpl_index,
  output logic [$clog2(bs+1)-1:0] occupancy,
  output logic                   full,
  output logic                   alloc_err
);

  localparam int iw = $clog2(bs);
  localparam int cw = $clog2(bs + 1);

  entry_state_t st [bs];
  logic [0:bs-1] dep [bs];
  logic [bs-1:0] ready_vec;

  logic          cmpl_ok;
  logic          alloc_ok;
  logic          issue_fire;
  logic [0:bs-1] self_m;
  logic [0:bs-1] cmpl_m;
  logic [0:bs-1] clr_m;
  logic [0:bs-1] masked;

  // A same-edge completion of the target entry frees it for reuse.
  always_comb begin
    cmpl_ok  = cmpl_valid && (st[cmpl_index] == ISSUED);
    alloc_ok = alloc_valid &&
               ((st[alloc_index] == FREE) ||
                (cmpl_ok && (cmpl_index == alloc_index)));
    issue_fire = issue_valid && issue_ready;
    self_m = '0;
    self_m[alloc_index] = 1'b1;
    cmpl_m = '0;
    if (cmpl_valid) cmpl_m[cmpl_index] = 1'b1;
    clr_m  = cmpl_ok ? cmpl_m : '0;
    masked = alloc_dept & ~self_m & ~cmpl_m;
  end

  for (genvar g = 0; g < bs; g++) begin : g_ent
    assign ready_vec[g] = (st[g] == READY);

    always_ff @(posedge clk) begin
      if (rst) begin
        st[g]  <= FREE;
        dep[g] <= '0;
      end else if (alloc_ok && (alloc_index == iw'(g))) begin
        dep[g] <= masked;
        st[g]  <= (|masked) ? WAIT : READY;
      end else begin
        dep[g] <= dep[g] & ~clr_m;
        // Wakeup looks at the registered row: one edge after the clear.
        case (st[g])
          WAIT:
            if (dep[g] == '0) st[g] <= READY;
          READY:
            if (issue_fire && (issue_index == iw'(g))) st[g] <= ISSUED;
          ISSUED:
            if (cmpl_ok && (cmpl_index == iw'(g))) st[g] <= FREE;
          default: st[g] <= st[g];
        endcase
      end
    end
  end

  prio_enc_lsb #(.n(bs)) u_pick (
    .req   (ready_vec),
    .found (issue_valid),
    .index (issue_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      alloc_err <= 1'b0;
    end else begin
      occupancy <= occupancy + cw'(alloc_ok) - cw'(cmpl_ok);
      alloc_err <= alloc_valid && !alloc_ok;
    end
  end

  assign full = (occupancy == cw'(bs));

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Self-checking bench: cycle vector table plus a fill/drain
// sequence scored against a queue of expected issue indices.
module tb_dep_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_index;
  logic [0:31] alloc_dept;
  logic        issue_valid;
  logic [4:0]  issue_index;
  logic        issue_ready;
  logic        cmpl_valid;
  logic [4:0]  cmpl_index;
  logic [5:0]  occupancy;
  logic        full;
  logic        alloc_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dep_issue_scheduler #(.bs(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_index (alloc_index),
    .alloc_dept  (alloc_dept),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_ready (issue_ready),
    .cmpl_valid  (cmpl_valid),
    .cmpl_index  (cmpl_index),
    .occupancy   (occupancy),
    .full        (full),
    .alloc_err   (alloc_err)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ai;
    logic [0:31] ad;
    logic        ir;
    logic        cv;
    logic [4:0]  ci;
    logic        ev;
    logic [4:0]  ei;
    logic [5:0]  occ;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   sb[$];

  function automatic logic [0:31] bit_of(int k);
    logic [0:31] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(logic r, logic av, int ai, logic [0:31] ad,
                              logic ir, logic cv, int ci, logic ev,
                              int ei, int occ, logic err);
    vec_t v;
    v.rst = r; v.av = av; v.ai = 5'(ai); v.ad = ad;
    v.ir = ir; v.cv = cv; v.ci = 5'(ci);
    v.ev = ev; v.ei = 5'(ei); v.occ = 6'(occ); v.err = err;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alloc_valid = 1'b0; alloc_index = '0; alloc_dept = '0;
    issue_ready = 1'b0; cmpl_valid = 1'b0; cmpl_index = '0;
  endtask

  initial begin
    logic [0:31] z;
    int exp_idx;
    z = '0;
    idle_inputs();
    rst = 1'b1;

    //          rst av ai dept              ir cv ci  ev ei occ err
    vecs.push_back(mk(1, 0, 0, z,           0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 0, 0,  0, 0, 0, 0));
    // simple alloc/issue/complete of entry 2
    vecs.push_back(mk(0, 1, 2, z,           1, 0, 0,  1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 1, 2,  0, 0, 0, 0));
    // entry 5 depends on entry 1
    vecs.push_back(mk(0, 1, 1, z,           0, 0, 0,  1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 5, bit_of(1),   0, 0, 0,  1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 1, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 0, 0,  1, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 1, 0));
    // alloc 7 (deps 3,7) with same-edge completion of 3
    vecs.push_back(mk(0, 1, 3, z,           0, 0, 0,  1, 3, 2, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 7, bit_of(3) | bit_of(7),
                                            0, 1, 3,  1, 7, 2, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 1, 5,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 1, 7,  0, 0, 0, 0));
    // double alloc of 4, completion of a READY entry
    vecs.push_back(mk(0, 1, 4, z,           0, 0, 0,  1, 4, 1, 0));
    vecs.push_back(mk(0, 1, 4, z,           0, 0, 0,  1, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0, z,           0, 0, 0,  1, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 1, 4,  1, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 1, 4,  0, 0, 0, 0));
    // same-edge completion and re-alloc of entry 6
    vecs.push_back(mk(0, 1, 6, z,           0, 0, 0,  1, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 6, z,           0, 1, 6,  1, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, z,           0, 1, 6,  0, 0, 0, 0));
    // three live entries then reset with a competing alloc
    vecs.push_back(mk(0, 1, 10, z,          0, 0, 0,  1, 10, 1, 0));
    vecs.push_back(mk(0, 1, 11, z,          0, 0, 0,  1, 10, 2, 0));
    vecs.push_back(mk(0, 1, 12, z,          0, 0, 0,  1, 10, 3, 0));
    vecs.push_back(mk(1, 1, 13, z,          1, 0, 0,  0, 0, 0, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; alloc_valid = vecs[k].av;
      alloc_index = vecs[k].ai; alloc_dept = vecs[k].ad;
      issue_ready = vecs[k].ir; cmpl_valid = vecs[k].cv;
      cmpl_index = vecs[k].ci;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.issue_valid", k), issue_valid, vecs[k].ev);
      if (vecs[k].ev)
        check($sformatf("v%0d.issue_index", k), issue_index, vecs[k].ei);
      else
        check($sformatf("v%0d.issue_index0", k), issue_index, 0);
      check($sformatf("v%0d.occupancy", k), occupancy, vecs[k].occ);
      check($sformatf("v%0d.full", k), full, 0);
      check($sformatf("v%0d.alloc_err", k), alloc_err, vecs[k].err);
    end

    // fill every entry with no dependencies, hold off issue
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      alloc_valid = 1'b1;
      alloc_index = 5'(i);
      sb.push_back(i);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    idle_inputs();
    check("fill.occupancy", occupancy, 32);
    check("fill.full", full, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("hold.issue_valid", issue_valid, 1);
      check("hold.issue_index", issue_index, 0);
    end

    // drain: each accepted issue must match the next queued index
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      issue_ready = 1'b1;
      #1;
      if (issue_valid) begin
        exp_idx = sb.pop_front();
        check("drain.issue_index", issue_index, exp_idx);
      end
      @(posedge clk);
    end
    @(negedge clk);
    issue_ready = 1'b0;
    check("drain.remaining", sb.size(), 0);
    check("drain.issue_valid", issue_valid, 0);
    check("drain.occupancy", occupancy, 32);
    check("drain.full", full, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
